// File: rtl/irq_pkg.sv
// irq_pkg: shared types and helpers for the prioritised interrupt controller
package irq_pkg;
  // All-ones IPL pattern meaning "no interrupt"; callers truncate it to IPL_W.
  localparam logic [31:0] IPL_NONE = 32'hFFFF_FFFF;
  // Width of the IRQ_ID bus: it must also encode the value NUM_IRQ for "none".
  function automatic int id_w(input int num);
    return $clog2(num + 1);
  endfunction
  // Active-low IPL for channel idx: level = num - idx, so channel 0 is the highest level.
  function automatic logic [31:0] ipl_of(input int idx, input int num);
    return ~(32'(num - idx));
  endfunction
endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: two-flop synchroniser plus previous-value flop yielding a one-cycle rising-edge pulse
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic rise
);
  logic sync1, sync2, prev;
  // Shift the asynchronous source through the synchroniser and the prev stage.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync1, sync2, prev} <= '0;
    else {sync1, sync2, prev} <= {src, sync1, sync2};
  assign rise = sync2 & ~prev;
endmodule

// File: rtl/irq_prio_ctrl.sv
// irq_prio_ctrl: prioritised interrupt controller; define IRQ_AUTOACK_EN to let IACK clear the presented channel
module irq_prio_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 3,
  parameter int IPL_W   = 3
) (
  input  logic                        CLK,
  input  logic                        nRESET,
  input  logic [NUM_IRQ-1:0]          IRQ_IN,
  input  logic [NUM_IRQ-1:0]          DIN,
  input  logic                        WR_ACK,
  input  logic                        WR_MASK,
  input  logic                        IACK,
  output logic [IPL_W-1:0]            nIPL,
  output logic [id_w(NUM_IRQ)-1:0]    IRQ_ID,
  output logic [NUM_IRQ-1:0]          PENDING,
  output logic [NUM_IRQ-1:0]          MASK
);
  localparam int ID_W = id_w(NUM_IRQ);
  localparam logic [ID_W-1:0] ID_NONE = ID_W'(NUM_IRQ);
  logic [NUM_IRQ-1:0] rise, clr, active;
  logic [ID_W-1:0]    win_id;
  logic [IPL_W-1:0]   win_ipl;
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_edge_sync u_sync (
      .clk  (CLK),
      .rst_n(nRESET),
      .src  (IRQ_IN[g]),
      .rise (rise[g])
    );
  end
`ifdef IRQ_AUTOACK_EN
  // Clear set: software ack bits plus the channel currently presented when IACK pulses.
  always_comb begin
    clr = WR_ACK ? DIN : '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (IACK && int'(IRQ_ID) == i) clr[i] = 1'b1;
  end
`else
  logic unused_iack;
  assign unused_iack = IACK;
  // Clear set: software ack bits only.
  always_comb clr = WR_ACK ? DIN : '0;
`endif
  // Pending bits are sticky; a new edge beats a same-cycle clear. Mask never touches pending.
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      PENDING <= '0;
      MASK    <= '1;
    end else begin
      PENDING <= (PENDING & ~clr) | rise;
      if (WR_MASK) MASK <= DIN;
    end
  // Fixed priority: the lowest-index enabled pending channel wins.
  always_comb begin
    active  = PENDING & MASK;
    win_id  = ID_NONE;
    win_ipl = IPL_W'(IPL_NONE);
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i]) begin
        win_id  = ID_W'(i);
        win_ipl = IPL_W'(ipl_of(i, NUM_IRQ));
      end
  end
  // Register the arbitration result so the CPU sees a glitch-free IPL bus.
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      nIPL   <= IPL_W'(IPL_NONE);
      IRQ_ID <= ID_NONE;
    end else begin
      nIPL   <= win_ipl;
      IRQ_ID <= win_id;
    end
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// tb_irq_prio_ctrl: directed scenarios plus randomized traffic against a sample-history reference model
module tb_irq_prio_ctrl;
  localparam int N = 3;
  localparam int W = 3;
  logic         CLK = 1'b0;
  logic         nRESET;
  logic [N-1:0] IRQ_IN, DIN;
  logic         WR_ACK, WR_MASK, IACK;
  logic [W-1:0] nIPL;
  logic [1:0]   IRQ_ID;
  logic [N-1:0] PENDING, MASK;
  int tests = 0;
  int fails = 0;

  irq_prio_ctrl #(.NUM_IRQ(N), .IPL_W(W)) dut (
    .CLK(CLK), .nRESET(nRESET), .IRQ_IN(IRQ_IN), .DIN(DIN), .WR_ACK(WR_ACK),
    .WR_MASK(WR_MASK), .IACK(IACK), .nIPL(nIPL), .IRQ_ID(IRQ_ID),
    .PENDING(PENDING), .MASK(MASK)
  );

  always #5 CLK = ~CLK;

  // Reference model: keeps the last three sampled IRQ_IN values; a channel pends two
  // edges after it is first sampled high, and outputs follow pending by one more edge.
  logic [N-1:0] h0, h1, h2, m_pend, m_mask, m_clr, m_rise, m_act;
  logic [1:0]   m_id, m_win;
  logic [W-1:0] m_nipl, m_ipl;
  always_comb begin
    m_rise = h1 & ~h2;
    m_clr  = WR_ACK ? DIN : '0;
`ifdef IRQ_AUTOACK_EN
    if (IACK && m_id != 2'(N)) m_clr[m_id] = 1'b1;
`endif
    m_act = m_pend & m_mask;
    m_win = 2'(N);
    for (int i = N - 1; i >= 0; i--) if (m_act[i]) m_win = 2'(i);
    m_ipl = (m_win == 2'(N)) ? W'(2**W - 1) : W'((2**W - 1) - (N - int'(m_win)));
  end
  always @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      m_pend <= '0; m_mask <= '1; m_id <= 2'(N); m_nipl <= '1;
    end else begin
      m_pend <= (m_pend & ~m_clr) | m_rise;
      if (WR_MASK) m_mask <= DIN;
      m_id <= m_win;
      m_nipl <= m_ipl;
      h2 <= h1; h1 <= h0; h0 <= IRQ_IN;
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_ack(input logic [N-1:0] d);
    WR_ACK = 1'b1; DIN = d;
    @(negedge CLK);
    WR_ACK = 1'b0; DIN = '0;
  endtask

  task automatic pulse_mask(input logic [N-1:0] d);
    WR_MASK = 1'b1; DIN = d;
    @(negedge CLK);
    WR_MASK = 1'b0; DIN = '0;
  endtask

  task automatic test_reset;
    nRESET = 1'b0; IRQ_IN = 3'b001; DIN = '0; WR_ACK = 0; WR_MASK = 0; IACK = 0;
    cyc(2);
    tests++; if (nIPL !== 3'b111) begin fails++; $display("FAIL reset_nipl got %b want 111", nIPL); end
    tests++; if (IRQ_ID !== 2'd3) begin fails++; $display("FAIL reset_id got %0d want 3", IRQ_ID); end
    tests++; if (PENDING !== 3'b000) begin fails++; $display("FAIL reset_pending got %b want 000", PENDING); end
    tests++; if (MASK !== 3'b111) begin fails++; $display("FAIL reset_mask got %b want 111", MASK); end
    nRESET = 1'b1;
    cyc(4);
    tests++; if (nIPL !== 3'b100) begin fails++; $display("FAIL powerup_nipl got %b want 100", nIPL); end
    tests++; if (IRQ_ID !== 2'd0) begin fails++; $display("FAIL powerup_id got %0d want 0", IRQ_ID); end
    tests++; if (PENDING !== 3'b001) begin fails++; $display("FAIL powerup_pending got %b want 001", PENDING); end
    IRQ_IN = '0;
    pulse_ack(3'b001);
    tests++; if (PENDING !== 3'b000) begin fails++; $display("FAIL ack_pending got %b want 000", PENDING); end
    cyc(1);
    tests++; if (nIPL !== 3'b111) begin fails++; $display("FAIL ack_nipl got %b want 111", nIPL); end
  endtask

  task automatic test_priority;
    IRQ_IN = 3'b110;
    cyc(4);
    tests++; if (nIPL !== 3'b101) begin fails++; $display("FAIL prio_nipl got %b want 101", nIPL); end
    tests++; if (IRQ_ID !== 2'd1) begin fails++; $display("FAIL prio_id got %0d want 1", IRQ_ID); end
    pulse_ack(3'b010);
    cyc(1);
    tests++; if (nIPL !== 3'b110) begin fails++; $display("FAIL prio_ack1_nipl got %b want 110", nIPL); end
    tests++; if (IRQ_ID !== 2'd2) begin fails++; $display("FAIL prio_ack1_id got %0d want 2", IRQ_ID); end
    IRQ_IN = '0;
    pulse_ack(3'b100);
    cyc(1);
    tests++; if (nIPL !== 3'b111) begin fails++; $display("FAIL prio_ack2_nipl got %b want 111", nIPL); end
    tests++; if (IRQ_ID !== 2'd3) begin fails++; $display("FAIL prio_ack2_id got %0d want 3", IRQ_ID); end
  endtask

  task automatic test_mask;
    pulse_mask(3'b101);
    IRQ_IN = 3'b010;
    cyc(4);
    tests++; if (MASK !== 3'b101) begin fails++; $display("FAIL mask_reg got %b want 101", MASK); end
    tests++; if (PENDING !== 3'b010) begin fails++; $display("FAIL mask_pending got %b want 010", PENDING); end
    tests++; if (nIPL !== 3'b111) begin fails++; $display("FAIL mask_nipl got %b want 111", nIPL); end
    pulse_mask(3'b111);
    cyc(1);
    tests++; if (nIPL !== 3'b101) begin fails++; $display("FAIL unmask_nipl got %b want 101", nIPL); end
    IRQ_IN = '0;
    pulse_ack(3'b010);
    cyc(1);
  endtask

  task automatic test_collision;
    IRQ_IN = 3'b100;
    cyc(2);
    pulse_ack(3'b100);
    tests++; if (PENDING[2] !== 1'b1) begin fails++; $display("FAIL collision_pending2 got %b want 1", PENDING[2]); end
    IRQ_IN = '0;
    pulse_ack(3'b100);
    cyc(2);
  endtask

  task automatic test_autoack;
    IRQ_IN = 3'b001;
    cyc(4);
    tests++; if (IRQ_ID !== 2'd0) begin fails++; $display("FAIL autoack_pre_id got %0d want 0", IRQ_ID); end
    IACK = 1'b1;
    cyc(1);
    IACK = 1'b0;
`ifdef IRQ_AUTOACK_EN
    tests++; if (PENDING !== 3'b000) begin fails++; $display("FAIL autoack_pending got %b want 000", PENDING); end
    cyc(1);
    tests++; if (nIPL !== 3'b111) begin fails++; $display("FAIL autoack_nipl got %b want 111", nIPL); end
`else
    tests++; if (PENDING !== 3'b001) begin fails++; $display("FAIL iack_ignored_pending got %b want 001", PENDING); end
    cyc(1);
    tests++; if (nIPL !== 3'b100) begin fails++; $display("FAIL iack_ignored_nipl got %b want 100", nIPL); end
`endif
    IRQ_IN = '0;
    pulse_ack(3'b001);
    cyc(2);
  endtask

  task automatic test_random;
    logic [N-1:0] t;
    for (int k = 0; k < 400; k++) begin
      @(negedge CLK);
      tests++; if (PENDING !== m_pend) begin fails++; $display("FAIL rand_pending cyc %0d got %b want %b", k, PENDING, m_pend); end
      tests++; if (MASK !== m_mask) begin fails++; $display("FAIL rand_mask cyc %0d got %b want %b", k, MASK, m_mask); end
      tests++; if (nIPL !== m_nipl) begin fails++; $display("FAIL rand_nipl cyc %0d got %b want %b", k, nIPL, m_nipl); end
      tests++; if (IRQ_ID !== m_id) begin fails++; $display("FAIL rand_id cyc %0d got %0d want %0d", k, IRQ_ID, m_id); end
      t = N'($urandom) & N'($urandom);
      IRQ_IN  = IRQ_IN ^ t;
      DIN     = N'($urandom);
      WR_ACK  = ($urandom_range(0, 4) == 0);
      WR_MASK = ($urandom_range(0, 6) == 0);
      IACK    = ($urandom_range(0, 3) == 0);
    end
    @(negedge CLK);
    WR_ACK = 0; WR_MASK = 0; IACK = 0; DIN = '0; IRQ_IN = '0;
  endtask

  task automatic test_async_reset;
    pulse_ack(3'b111);
    cyc(2);
    IRQ_IN = 3'b111;
    cyc(4);
    tests++; if (PENDING !== 3'b111) begin fails++; $display("FAIL arst_pre_pending got %b want 111", PENDING); end
    #2 nRESET = 1'b0;
    #1;
    tests++; if (PENDING !== 3'b000) begin fails++; $display("FAIL arst_pending got %b want 000", PENDING); end
    tests++; if (nIPL !== 3'b111) begin fails++; $display("FAIL arst_nipl got %b want 111", nIPL); end
    tests++; if (MASK !== 3'b111) begin fails++; $display("FAIL arst_mask got %b want 111", MASK); end
    tests++; if (IRQ_ID !== 2'd3) begin fails++; $display("FAIL arst_id got %0d want 3", IRQ_ID); end
    IRQ_IN = '0;
    @(negedge CLK);
    nRESET = 1'b1;
    cyc(2);
  endtask

  initial begin
    test_reset;
    test_priority;
    test_mask;
    test_collision;
    test_autoack;
    test_random;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised prioritised interrupt controller for the 68k side of the system block. It takes NUM_IRQ asynchronous interrupt sources and synchronises and edge-detects each one into a sticky pending bit. Pending bits are cleared by CPU acknowledge writes, and a mask register gates which pending bits take part in arbitration. The highest-priority unmasked pending channel drives the registered active-low IPL bus.

## Interface
- NUM_IRQ, 3: number of interrupt channels; channel 0 has the highest priority.
- IPL_W, 3: width of IPL bus; requires NUM_IRQ <= 2^IPL_W - 1.
- CLK  in  1  system clock; all state on rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- IRQ_IN  in  NUM_IRQ  raw interrupt sources, asynchronous, rising-edge triggered.
- DIN  in  NUM_IRQ  write data for the ack and mask strobes.
- WR_ACK  in  1  single-cycle strobe; clears pending bits where DIN=1.
- WR_MASK  in  1  single-cycle strobe; loads MASK from DIN (1 = enabled).
- IACK  in  1  CPU interrupt-acknowledge pulse; only used with IRQ_AUTOACK_EN.
- nIPL  out  IPL_W  registered active-low interrupt level to the CPU.
- IRQ_ID  out  $clog2(NUM_IRQ+1)  registered ID of the presented channel; NUM_IRQ = none.
- PENDING  out  NUM_IRQ  raw pending register, unmasked, for status readback.
- MASK  out  NUM_IRQ  current mask register.

## Operation
- Per channel: two-flop synchroniser, then a prev flop. edge = sync2 & ~prev.
- The pending bit is set on edge. It is cleared by WR_ACK with DIN[i]=1, or by auto-ack (see Configuration).
- Set and clear in the same cycle: set wins, so the new edge is never lost.
- Masked channels still latch pending. They are only excluded from arbitration; unmasking later presents them.
- Arbitration: active = PENDING & MASK. The winner is the lowest set index i.
- Level for channel i = NUM_IRQ - i, so channel 0 is the highest level. nIPL = ~level, zero-extended to IPL_W before inversion.
- No active channel: level 0, nIPL all ones, IRQ_ID = NUM_IRQ.
- WR_ACK and WR_MASK in the same cycle: both apply. The mask update does not affect pending.
- Reset values: sync, prev and PENDING are all 0; MASK is all 1; nIPL is all 1; IRQ_ID = NUM_IRQ.
- Because prev resets to 0, a source held high through reset registers one edge after reset is released. This is intended and makes the power-up reset IRQ fire.
- Reset asserted mid-operation clears all state immediately and asynchronously, including pending edges in flight.

## Timing
- Call E0 the first rising edge that samples IRQ_IN[i] high, given that it was sampled low at the previous edge.
  - E0: sync1 = 1.
  - E1: sync2 = 1.
  - E2: PENDING[i] = 1.
  - E3: nIPL and IRQ_ID updated.
- The pending-to-output path always takes 1 cycle of latency, including changes to MASK and clears by ack.
- After a WR_ACK at edge En, PENDING clears at En and nIPL re-arbitrates at En+1.
- Source pulses shorter than one CLK period may be missed. Sources must hold for at least 2 CLK periods.
- A new rising edge needs the source low for at least 1 sampled cycle after its previous high.

## Configuration
- IRQ_AUTOACK_EN defined:
  - An IACK pulse clears PENDING[IRQ_ID] at that edge, using the registered IRQ_ID.
  - IACK while IRQ_ID = NUM_IRQ does nothing.
  - A simultaneous edge on the same channel wins.
  - IACK combined with WR_ACK clears the union of both.
- IRQ_AUTOACK_EN undefined: IACK is ignored, and pending bits are cleared only by WR_ACK.

## Structure
- Package irq_pkg holds:
  - the level function (channel index to active-low IPL);
  - the IPL_NONE constant (all ones);
  - the ID-width helper.
- Sub-module irq_edge_sync holds one channel's sync1/sync2/prev chain and its edge output. It is instantiated NUM_IRQ times via generate.
- Pending, mask, arbitration and output registers live in the top level.

## Test plan
All scenarios use NUM_IRQ=3 and IPL_W=3.
- **Reset power-up:** IRQ_IN=3'b001 held through reset, then reset released → nIPL=3'b100 and IRQ_ID=0 three edges after release; PENDING=3'b001.
- **Priority:** edges on channels 1 and 2 in the same cycle → nIPL=3'b101 and IRQ_ID=1. Then WR_ACK with DIN=3'b010 → next cycle nIPL=3'b110 and IRQ_ID=2. Then WR_ACK with DIN=3'b100 → nIPL=3'b111 and IRQ_ID=3.
- **Mask:** WR_MASK with DIN=3'b101, then an edge on channel 1 → PENDING=3'b010 and nIPL stays 3'b111. Then WR_MASK with DIN=3'b111 → nIPL=3'b101 one cycle later.
- **Set/clear collision:** WR_ACK with DIN=3'b100 on the same edge that channel 2 sets pending → PENDING[2] remains 1.
- **Auto-ack (IRQ_AUTOACK_EN):** channel 0 pending, IACK pulse → PENDING[0]=0 and nIPL=3'b111 next cycle. Without the macro, the same stimulus leaves PENDING=3'b001.
- **Async reset mid-operation:** all channels pending, nRESET pulsed low between clock edges → immediately PENDING=0, nIPL=3'b111, MASK=3'b111 and IRQ_ID=3.
